// File: rtl/pipe_ctrl_if.sv
// Control-path bundle between the pipeline stages and the pipeline controller.
// master drives requests/redirects and observes holds; slave is the controller.
interface pipe_ctrl_if;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        int_assert_i;
  logic [31:0] int_addr_i;
  logic        hold_req_ex_i;
  logic        hold_req_bus_i;
  logic        hold_req_int_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        bus_timeout_o;

  modport master (
    output jump_flag_i, jump_addr_i, int_assert_i, int_addr_i,
    output hold_req_ex_i, hold_req_bus_i, hold_req_int_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, int_assert_i, int_addr_i,
    input  hold_req_ex_i, hold_req_bus_i, hold_req_int_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: PC redirect muxing, post-redirect flush sequencing,
// stall-level arbitration and a bus-hold watchdog.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave ctrl
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] BUS_LAST   = 16'(BUS_TIMEOUT - 1);

  logic [0:0]  state_reg, state_next;
  logic [3:0]  flush_cnt_reg, flush_cnt_next;
  logic [15:0] bus_cnt_reg, bus_cnt_next;
  logic        timeout_reg, timeout_next;
  logic        redirect;
  logic [2:0]  hold_level;

  assign redirect = ctrl.jump_flag_i | ctrl.int_assert_i;

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    if (redirect) begin
      // A redirect always restarts the flush window, even mid-flush.
      state_next     = ST_FLUSH;
      flush_cnt_next = FLUSH_LOAD;
    end else if (state_reg == ST_FLUSH) begin
      if (flush_cnt_reg == 4'd0) begin
        state_next = ST_IDLE;
      end else begin
        flush_cnt_next = flush_cnt_reg - 4'd1;
      end
    end
  end

  // Watchdog tracks the raw bus hold, regardless of FSM state or other holds.
  always_comb begin
    bus_cnt_next = 16'd0;
    timeout_next = 1'b0;
    if (ctrl.hold_req_bus_i) begin
      if (bus_cnt_reg == BUS_LAST) begin
        timeout_next = 1'b1;
      end else begin
        bus_cnt_next = bus_cnt_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      flush_cnt_reg <= 4'd0;
      bus_cnt_reg   <= 16'd0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      bus_cnt_reg   <= bus_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    hold_level = HOLD_NONE;
    if (rst) begin
      hold_level = HOLD_NONE;
    end else if (redirect || ctrl.hold_req_ex_i || (state_reg == ST_FLUSH)) begin
      hold_level = HOLD_ID;
    end else if (ctrl.hold_req_bus_i || ctrl.hold_req_int_i) begin
      hold_level = HOLD_PC;
    end
  end

  assign ctrl.hold_flag_o   = hold_level;
  assign ctrl.jump_flag_o   = redirect & ~rst;
  assign ctrl.jump_addr_o   = rst ? 32'd0 :
                              (ctrl.int_assert_i ? ctrl.int_addr_i : ctrl.jump_addr_i);
  assign ctrl.bus_timeout_o = timeout_reg;

endmodule
